// File: rtl/uv_spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// uv_spi_arb_pkg
// Shared types and constants for the SPI bus-slave arbiter.
//   state_t  : arbiter FSM states (TMO/DRAIN are only reachable when the
//              design is built with UV_SPI_ARB_TIMEOUT_EN defined)
//   EXCP_OK  : normal response exception code
//   EXCP_TMO : exception code returned for an aborted (timed-out) access
// ---------------------------------------------------------------------------
package uv_spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RSP,
    TMO,
    DRAIN
  } state_t;

  localparam logic [1:0] EXCP_OK  = 2'b00;
  localparam logic [1:0] EXCP_TMO = 2'b10;

endpackage

// File: rtl/uv_rr_arb.sv
// ---------------------------------------------------------------------------
// uv_rr_arb
// Purely combinational round-robin grant. Picks the first asserted request
// at or after ptr, wrapping modulo REQ_NUM.
// Ports:
//   req [REQ_NUM-1:0] in  : request vector
//   ptr [PW-1:0]      in  : highest-priority index (must be < REQ_NUM)
//   gnt [REQ_NUM-1:0] out : one-hot grant (all zero when no request)
//   idx [PW-1:0]      out : index of the granted request (0 when none)
// ---------------------------------------------------------------------------
module uv_rr_arb #(
  parameter int REQ_NUM = 2,
  parameter int PW      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [REQ_NUM-1:0] gnt,
  output logic [PW-1:0]      idx
);

  // Walk the rotated priority order from lowest priority to highest so the
  // last hit (the one closest to ptr) is the one that sticks.
  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= REQ_NUM) begin
        cand = cand - REQ_NUM;
      end
      if (req[cand[PW-1:0]]) begin
        gnt                 = '0;
        gnt[cand[PW-1:0]]   = 1'b1;
        idx                 = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uv_spi_arb.sv
// ---------------------------------------------------------------------------
// uv_spi_arb
// Round-robin arbiter sharing the single bus slave port of the SPI controller
// between REQ_NUM masters. One outstanding transaction at a time; the
// response is routed back to the master that issued the request.
//
// Optional feature: define UV_SPI_ARB_TIMEOUT_EN to abort a transaction whose
// response does not arrive within TMO_CNT RSP cycles. The master then gets
// EXCP_TMO, and the late slave response is swallowed in DRAIN.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   m_req_vld/rdy/read  [REQ_NUM] : per-master request handshake + direction
//   m_req_addr/mask/data          : packed request fields, master i at slice i
//   m_rsp_vld/rdy       [REQ_NUM] : per-master response handshake
//   m_rsp_excp/data               : packed response fields, master i at slice i
//   spi_req_*                     : registered request to the SPI controller
//   spi_rsp_*                     : response from the SPI controller
// ---------------------------------------------------------------------------
module uv_spi_arb
  import uv_spi_arb_pkg::*;
#(
  parameter int ALEN    = 12,
  parameter int DLEN    = 32,
  parameter int MLEN    = DLEN / 8,
  parameter int REQ_NUM = 2,
  parameter int TMO_CNT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [REQ_NUM-1:0]      m_req_vld,
  output logic [REQ_NUM-1:0]      m_req_rdy,
  input  logic [REQ_NUM-1:0]      m_req_read,
  input  logic [REQ_NUM*ALEN-1:0] m_req_addr,
  input  logic [REQ_NUM*MLEN-1:0] m_req_mask,
  input  logic [REQ_NUM*DLEN-1:0] m_req_data,

  output logic [REQ_NUM-1:0]      m_rsp_vld,
  input  logic [REQ_NUM-1:0]      m_rsp_rdy,
  output logic [REQ_NUM*2-1:0]    m_rsp_excp,
  output logic [REQ_NUM*DLEN-1:0] m_rsp_data,

  output logic                    spi_req_vld,
  input  logic                    spi_req_rdy,
  output logic                    spi_req_read,
  output logic [ALEN-1:0]         spi_req_addr,
  output logic [MLEN-1:0]         spi_req_mask,
  output logic [DLEN-1:0]         spi_req_data,

  input  logic                    spi_rsp_vld,
  output logic                    spi_rsp_rdy,
  input  logic [1:0]              spi_rsp_excp,
  input  logic [DLEN-1:0]         spi_rsp_data
);

  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  if (REQ_NUM < 2 || TMO_CNT < 2) begin : g_param_err
    $error("uv_spi_arb: REQ_NUM and TMO_CNT must both be at least 2");
  end

  state_t            state_reg;
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     own_reg;
  logic              read_reg;
  logic [ALEN-1:0]   addr_reg;
  logic [MLEN-1:0]   mask_reg;
  logic [DLEN-1:0]   data_reg;

  logic [REQ_NUM-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      own_inc;
  logic               idle_st;
  logic               rsp_st;
  logic               tmo_st;
  logic               drain_st;
  logic               req_hs;

`ifdef UV_SPI_ARB_TIMEOUT_EN
  localparam int            TW       = $clog2(TMO_CNT);
  localparam logic [TW-1:0] CNT_LAST = TW'(TMO_CNT - 1);
  logic [TW-1:0]            cnt_reg;
`endif

  uv_rr_arb #(
    .REQ_NUM (REQ_NUM),
    .PW      (PW)
  ) u_rr_arb (
    .req (m_req_vld),
    .ptr (ptr_reg),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign idle_st = (state_reg == IDLE);
  assign rsp_st  = (state_reg == RSP);
`ifdef UV_SPI_ARB_TIMEOUT_EN
  assign tmo_st   = (state_reg == TMO);
  assign drain_st = (state_reg == DRAIN);
`else
  assign tmo_st   = 1'b0;
  assign drain_st = 1'b0;
`endif

  // Ready is held low while reset is asserted so requesters never see a
  // grant during reset, even though the FSM already sits in IDLE.
  assign m_req_rdy = (idle_st && !rst) ? gnt : '0;
  // The arbiter only grants an asserted request, so any request is a handshake.
  assign req_hs    = idle_st && (|m_req_vld);
  assign own_inc   = (own_reg == PW'(REQ_NUM - 1)) ? '0 : own_reg + PW'(1);

  assign spi_req_vld  = (state_reg == REQ);
  assign spi_req_read = read_reg;
  assign spi_req_addr = addr_reg;
  assign spi_req_mask = mask_reg;
  assign spi_req_data = data_reg;

  // DRAIN accepts the stale slave response unconditionally.
  assign spi_rsp_rdy = rsp_st ? m_rsp_rdy[own_reg] : drain_st;

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_rsp
    logic own_sel;
    assign own_sel = (own_reg == PW'(gi));
    assign m_rsp_vld[gi] = own_sel & ((rsp_st & spi_rsp_vld) | tmo_st);
    assign m_rsp_excp[gi*2 +: 2] = (own_sel && rsp_st) ? spi_rsp_excp :
                                   (own_sel && tmo_st) ? EXCP_TMO : EXCP_OK;
    assign m_rsp_data[gi*DLEN +: DLEN] = (own_sel && rsp_st) ? spi_rsp_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      own_reg   <= '0;
      read_reg  <= 1'b0;
      addr_reg  <= '0;
      mask_reg  <= '0;
      data_reg  <= '0;
`ifdef UV_SPI_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_hs) begin
            own_reg   <= gnt_idx;
            read_reg  <= m_req_read[gnt_idx];
            addr_reg  <= m_req_addr[gnt_idx*ALEN +: ALEN];
            mask_reg  <= m_req_mask[gnt_idx*MLEN +: MLEN];
            data_reg  <= m_req_data[gnt_idx*DLEN +: DLEN];
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (spi_req_rdy) begin
            state_reg <= RSP;
`ifdef UV_SPI_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
          end
        end
        RSP: begin
          if (spi_rsp_vld) begin
            // A real response always wins, even in the expiry cycle.
            if (m_rsp_rdy[own_reg]) begin
              ptr_reg   <= own_inc;
              state_reg <= IDLE;
            end
          end
`ifdef UV_SPI_ARB_TIMEOUT_EN
          else if (cnt_reg == CNT_LAST) begin
            state_reg <= TMO;
          end else begin
            cnt_reg <= cnt_reg + TW'(1);
          end
`endif
        end
`ifdef UV_SPI_ARB_TIMEOUT_EN
        TMO: begin
          if (m_rsp_rdy[own_reg]) begin
            ptr_reg   <= own_inc;
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (spi_rsp_vld) begin
            state_reg <= IDLE;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
